count_monitor_311: RTL and testbench
====================================

Name: count_monitor_311

Overview:
- Reader-side companion to the team's 4-bit up/down counter.
- Samples a counter's count bus and recovers step direction and wrap events.
- Flags illegal jumps and keeps a saturating step total.
- Sits beside any counter instance as a checker/telemetry block; the bus is sampled on the posedge of the shared clock, where the negedge-updated count is stable.

Parameters:
- W, 4, width of the monitored count bus.
- SW, 16, width of the step accumulator.

Ports:
- clk_311  in  1  clock; all registers update on posedge.
- reset_311  in  1  synchronous, active-high reset.
- count_in_311  in  W  monitored count value.
- valid_311  in  1  sample enable; count_in_311 is considered only when high.
- ctr_reset_311  in  1  mirror of the monitored counter's reset; qualifies a legal reload.
- ud_in_311  in  1  mirror of the counter's up/down select (1 = up); picks the expected reload value.
- clr_err_311  in  1  clears the sticky error and returns the FSM to SYNC_HOLD.
- dir_311  out  2  last step: 00 hold, 01 up, 10 down, 11 unknown.
- wrap_311  out  1  one-cycle pulse on a wrap step.
- err_311  out  1  sticky illegal-transition flag.
- steps_311  out  SW  saturating count of non-hold steps.
- reversals_311  out  8  direction-change count (optional feature).

Behaviour:
- Reset values: dir_311=11, wrap_311=0, err_311=0, steps_311=0, reversals_311=0, prev=0, state=UNSYNC.
- All outputs are registered and reflect the sample taken on the previous posedge (1-cycle latency).
- valid_311=0: state, prev and all outputs hold; wrap_311 forced 0.
- Step arithmetic: delta = count_in_311 - prev modulo 2^W.
  - delta 0 = hold.
  - delta 1 = up.
  - delta 2^W-1 = down.
  - Any other delta = illegal.
- FSM states: UNSYNC, SYNC_HOLD, SYNC_UP, SYNC_DOWN, FAULT.
- UNSYNC + valid: capture prev, go to SYNC_HOLD, dir=00, no error check.
- SYNC_* + valid, priority order:
  - ctr_reset_311=1 (reload):
    - Expected value is 0 if ud_in_311=1, else 2^W-1 (the counter's 255 truncates to 15 at W=4).
    - Match: baseline reloaded, SYNC_HOLD, dir=00, steps unchanged, no wrap.
    - Mismatch: FAULT.
  - Hold: SYNC_HOLD, dir=00.
  - Up: SYNC_UP, dir=01, steps+1. wrap pulse if prev=2^W-1.
  - Down: SYNC_DOWN, dir=10, steps+1. wrap pulse if prev=0.
  - Illegal: FAULT, err_311=1, dir=11.
- prev is updated on every valid sample, including in FAULT.
- FAULT: dir=11, steps frozen. Exits only via clr_err_311 or reset_311.
- clr_err_311: err=0, state=SYNC_HOLD, prev=count_in_311 if valid else unchanged. If clr_err_311 and an illegal step coincide, clear wins.
- steps_311 saturates at 2^SW-1 and never wraps.
- reset_311 mid-operation overrides everything, including clr_err_311, and returns to UNSYNC.

Optional Feature:
- Macro COUNT_MON_REVERSALS_EN.
- Defined: reversals_311 increments (saturating at 255) on every direct transition SYNC_UP→SYNC_DOWN or SYNC_DOWN→SYNC_UP. Passing through SYNC_HOLD resets the reversal context, so up, hold, down does not count.
- Undefined: no counter logic is built and reversals_311 is tied to 0; the port list is unchanged.

Decomposition:
- Package count_mon_311_pkg holds:
  - state enum (UNSYNC..FAULT),
  - DIR_HOLD/DIR_UP/DIR_DOWN/DIR_UNK 2-bit constants,
  - default W and SW.
- One combinational sub-module, step_classify_311: takes prev, cur and W, returns hold/up/down/illegal plus the wrap qualifier.
- FSM and accumulators stay in the top module.

Test Plan:
- Reset, then valid samples 3,4,5 → dir=01 after the 2nd and 3rd samples, steps_311=2, err=0.
- Up samples 14,15,0 → wrap_311 high exactly one cycle after the 0 sample, dir=01, steps=2.
- Samples 5,5,4 → dir 00 then 10, steps=1. Then 6 (delta 2) → err=1, dir=11, steps frozen at 1. clr_err_311 pulse → err=0, state SYNC_HOLD.
- Sample 9, then ctr_reset_311=1 with ud_in_311=0 and count 15 → no error, dir=00, steps unchanged. Repeat with count 0 → err=1.
- valid_311 low for 5 cycles while count_in_311 changes arbitrarily → all outputs stable. Assert reset_311 mid-sequence → outputs return to reset values next cycle.
- With COUNT_MON_REVERSALS_EN: samples 2,3,2,3 → reversals_311=2; samples 2,3,3,2 → reversals_311=0. Without the macro → reversals_311=0 throughout.

Source files
------------

// File: rtl/count_monitor_311_pkg.sv
// Shared types and constants for the count_monitor_311 block: FSM states,
// direction codes and default bus widths.
package count_mon_311_pkg;

  localparam int W_DEF  = 4;
  localparam int SW_DEF = 16;

  typedef enum logic [2:0] {
    UNSYNC    = 3'd0,
    SYNC_HOLD = 3'd1,
    SYNC_UP   = 3'd2,
    SYNC_DOWN = 3'd3,
    FAULT     = 3'd4
  } state_e;

  localparam logic [1:0] DIR_HOLD = 2'b00;
  localparam logic [1:0] DIR_UP   = 2'b01;
  localparam logic [1:0] DIR_DOWN = 2'b10;
  localparam logic [1:0] DIR_UNK  = 2'b11;

endpackage

// File: rtl/count_monitor_311_if.sv
// Bus between a sampling agent (master) and the count monitor (slave).
interface count_monitor_311_if #(
  parameter int W  = count_mon_311_pkg::W_DEF,
  parameter int SW = count_mon_311_pkg::SW_DEF
);
  logic [W-1:0]  count_in_311;
  logic          valid_311;
  logic          ctr_reset_311;
  logic          ud_in_311;
  logic          clr_err_311;
  logic [1:0]    dir_311;
  logic          wrap_311;
  logic          err_311;
  logic [SW-1:0] steps_311;
  logic [7:0]    reversals_311;

  modport master (
    output count_in_311, valid_311, ctr_reset_311, ud_in_311, clr_err_311,
    input  dir_311, wrap_311, err_311, steps_311, reversals_311
  );

  modport slave (
    input  count_in_311, valid_311, ctr_reset_311, ud_in_311, clr_err_311,
    output dir_311, wrap_311, err_311, steps_311, reversals_311
  );
endinterface

// File: rtl/count_monitor_311_step_classify.sv
// Combinational step classifier: sorts prev->cur into hold/up/down/illegal
// using modulo-2^W difference and flags steps that cross the wrap point.
module step_classify_311 #(
  parameter int W = 4
) (
  input  logic [W-1:0] prev_i,
  input  logic [W-1:0] cur_i,
  output logic         hold_o,
  output logic         up_o,
  output logic         down_o,
  output logic         illegal_o,
  output logic         wrap_o
);
  logic [W-1:0] delta_s;

  assign delta_s = cur_i - prev_i;

  always_comb begin
    hold_o    = (delta_s == {W{1'b0}});
    up_o      = (delta_s == W'(1));
    down_o    = (delta_s == {W{1'b1}});
    illegal_o = !(hold_o || up_o || down_o);
    wrap_o    = (up_o && (prev_i == {W{1'b1}})) || (down_o && (prev_i == {W{1'b0}}));
  end
endmodule

// File: rtl/count_monitor_311.sv
// Count-bus monitor: tracks step direction, wrap pulses, sticky illegal-jump
// error and a saturating step total. Optional reversal counter under
// COUNT_MON_REVERSALS_EN.
module count_monitor_311
  import count_mon_311_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = SW_DEF
) (
  input  logic                clk_311,
  input  logic                reset_311,
  count_monitor_311_if.slave  bus
);
  state_e        state_q, state_d;
  logic [W-1:0]  prev_q, prev_d;
  logic [1:0]    dir_q, dir_d;
  logic          wrap_q, wrap_d;
  logic          err_q, err_d;
  logic [SW-1:0] steps_q, steps_d;

  logic hold_s, up_s, down_s, illegal_s, wrap_s;
  logic reload_ok_s;
  logic sync_s;

  step_classify_311 #(.W(W)) u_classify (
    .prev_i    (prev_q),
    .cur_i     (bus.count_in_311),
    .hold_o    (hold_s),
    .up_o      (up_s),
    .down_o    (down_s),
    .illegal_o (illegal_s),
    .wrap_o    (wrap_s)
  );

  // An up-counter reloads to 0, a down-counter to all-ones.
  assign reload_ok_s = bus.ud_in_311 ? (bus.count_in_311 == {W{1'b0}})
                                     : (bus.count_in_311 == {W{1'b1}});
  assign sync_s = (state_q == SYNC_HOLD) || (state_q == SYNC_UP) || (state_q == SYNC_DOWN);

  always_ff @(posedge clk_311) begin
    if (reset_311) begin
      state_q <= UNSYNC;
      prev_q  <= {W{1'b0}};
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    if (bus.clr_err_311) begin
      state_d = SYNC_HOLD;
      prev_d  = bus.valid_311 ? bus.count_in_311 : prev_q;
    end else if (bus.valid_311) begin
      prev_d = bus.count_in_311;
      case (state_q)
        UNSYNC: state_d = SYNC_HOLD;
        SYNC_HOLD, SYNC_UP, SYNC_DOWN: begin
          if (bus.ctr_reset_311) state_d = reload_ok_s ? SYNC_HOLD : FAULT;
          else if (illegal_s)    state_d = FAULT;
          else if (hold_s)       state_d = SYNC_HOLD;
          else if (up_s)         state_d = SYNC_UP;
          else                   state_d = SYNC_DOWN;
        end
        FAULT:   state_d = FAULT;
        default: state_d = UNSYNC;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  always_comb begin
    dir_d   = dir_q;
    wrap_d  = 1'b0;
    err_d   = err_q;
    steps_d = steps_q;
    if (bus.clr_err_311) begin
      err_d = 1'b0;
      dir_d = DIR_HOLD;
    end else if (bus.valid_311 && sync_s) begin
      if (bus.ctr_reset_311) begin
        dir_d = reload_ok_s ? DIR_HOLD : DIR_UNK;
        err_d = err_q || !reload_ok_s;
      end else if (illegal_s) begin
        dir_d = DIR_UNK;
        err_d = 1'b1;
      end else if (hold_s) begin
        dir_d = DIR_HOLD;
      end else begin
        dir_d   = up_s ? DIR_UP : DIR_DOWN;
        wrap_d  = wrap_s;
        steps_d = (steps_q == {SW{1'b1}}) ? steps_q : steps_q + SW'(1);
      end
    end else if (bus.valid_311) begin
      dir_d = (state_q == UNSYNC) ? DIR_HOLD : DIR_UNK;
    end else begin
      dir_d = dir_q;
    end
  end

  always_ff @(posedge clk_311) begin
    if (reset_311) begin
      dir_q   <= DIR_UNK;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
      steps_q <= {SW{1'b0}};
    end else begin
      dir_q   <= dir_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
      steps_q <= steps_d;
    end
  end

  assign bus.dir_311   = dir_q;
  assign bus.wrap_311  = wrap_q;
  assign bus.err_311   = err_q;
  assign bus.steps_311 = steps_q;

`ifdef COUNT_MON_REVERSALS_EN
  logic [7:0] rev_q, rev_d;

  // Only a direct UP<->DOWN state change counts; a HOLD in between breaks it.
  always_comb begin
    rev_d = rev_q;
    if (((state_q == SYNC_UP && state_d == SYNC_DOWN) ||
         (state_q == SYNC_DOWN && state_d == SYNC_UP)) && (rev_q != 8'hFF)) begin
      rev_d = rev_q + 8'd1;
    end else begin
      rev_d = rev_q;
    end
  end

  always_ff @(posedge clk_311) begin
    if (reset_311) rev_q <= 8'd0;
    else           rev_q <= rev_d;
  end

  assign bus.reversals_311 = rev_q;
`else
  assign bus.reversals_311 = 8'd0;
`endif

endmodule

// File: tb/tb_count_monitor_311.sv
// Directed self-checking bench for count_monitor_311 (reversal expectations
// follow COUNT_MON_REVERSALS_EN).
module tb_count_monitor_311;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  count_monitor_311_if bus ();

  count_monitor_311 dut (
    .clk_311   (clk),
    .reset_311 (rst),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] d, input logic w,
                         input logic e, input logic [15:0] s);
    chk({tag, ".dir"},   {30'd0, bus.dir_311}, {30'd0, d});
    chk({tag, ".wrap"},  {31'd0, bus.wrap_311}, {31'd0, w});
    chk({tag, ".err"},   {31'd0, bus.err_311}, {31'd0, e});
    chk({tag, ".steps"}, {16'd0, bus.steps_311}, {16'd0, s});
  endtask

  task automatic smp(input logic v, input logic [3:0] c, input logic cr = 1'b0,
                     input logic ud = 1'b0, input logic clr = 1'b0);
    @(negedge clk);
    bus.valid_311     = v;
    bus.count_in_311  = c;
    bus.ctr_reset_311 = cr;
    bus.ud_in_311     = ud;
    bus.clr_err_311   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic rst_cycle();
    @(negedge clk);
    rst = 1'b1;
    bus.valid_311 = 1'b0;
    bus.clr_err_311 = 1'b0;
    bus.ctr_reset_311 = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [7:0] rev_exp;
    bus.count_in_311 = 4'd0;
    bus.valid_311 = 1'b0;
    bus.ctr_reset_311 = 1'b0;
    bus.ud_in_311 = 1'b0;
    bus.clr_err_311 = 1'b0;

    // Reset state
    rst_cycle();
    chk_out("reset", 2'b11, 1'b0, 1'b0, 16'd0);
    chk("reset.rev", {24'd0, bus.reversals_311}, 32'd0);

    // Up run 3,4,5
    smp(1'b1, 4'd3); chk_out("up3", 2'b00, 1'b0, 1'b0, 16'd0);
    smp(1'b1, 4'd4); chk_out("up4", 2'b01, 1'b0, 1'b0, 16'd1);
    smp(1'b1, 4'd5); chk_out("up5", 2'b01, 1'b0, 1'b0, 16'd2);

    // Up wrap 14,15,0 then 1
    rst_cycle();
    smp(1'b1, 4'd14); chk_out("w14", 2'b00, 1'b0, 1'b0, 16'd0);
    smp(1'b1, 4'd15); chk_out("w15", 2'b01, 1'b0, 1'b0, 16'd1);
    smp(1'b1, 4'd0);  chk_out("w0",  2'b01, 1'b1, 1'b0, 16'd2);
    smp(1'b1, 4'd1);  chk_out("w1",  2'b01, 1'b0, 1'b0, 16'd3);

    // Hold, down, illegal, fault freeze, clear
    rst_cycle();
    smp(1'b1, 4'd5); chk_out("h5a", 2'b00, 1'b0, 1'b0, 16'd0);
    smp(1'b1, 4'd5); chk_out("h5b", 2'b00, 1'b0, 1'b0, 16'd0);
    smp(1'b1, 4'd4); chk_out("d4",  2'b10, 1'b0, 1'b0, 16'd1);
    smp(1'b1, 4'd6); chk_out("ill6", 2'b11, 1'b0, 1'b1, 16'd1);
    smp(1'b1, 4'd7); chk_out("flt7", 2'b11, 1'b0, 1'b1, 16'd1);
    smp(1'b0, 4'd2, 1'b0, 1'b0, 1'b1); chk_out("clr", 2'b00, 1'b0, 1'b0, 16'd1);
    smp(1'b1, 4'd8); chk_out("post8", 2'b01, 1'b0, 1'b0, 16'd2);

    // Reload checks
    smp(1'b1, 4'd9);                    chk_out("s9",   2'b01, 1'b0, 1'b0, 16'd3);
    smp(1'b1, 4'd15, 1'b1, 1'b0);       chk_out("rl15", 2'b00, 1'b0, 1'b0, 16'd3);
    smp(1'b1, 4'd0,  1'b1, 1'b0);       chk_out("rl0b", 2'b11, 1'b0, 1'b1, 16'd3);
    smp(1'b1, 4'd2, 1'b0, 1'b0, 1'b1);  chk_out("clr2", 2'b00, 1'b0, 1'b0, 16'd3);
    smp(1'b1, 4'd0,  1'b1, 1'b1);       chk_out("rlu0", 2'b00, 1'b0, 1'b0, 16'd3);
    smp(1'b1, 4'd15);                   chk_out("dwrap", 2'b10, 1'b1, 1'b0, 16'd4);

    // valid low: outputs hold, wrap forced low
    for (int i = 0; i < 5; i++) begin
      smp(1'b0, 4'(i * 3 + 1));
      chk_out("vlow", 2'b10, 1'b0, 1'b0, 16'd4);
    end
    rst_cycle();
    chk_out("midrst", 2'b11, 1'b0, 1'b0, 16'd0);

    // Clear wins over a coincident illegal step
    smp(1'b1, 4'd1);                    chk_out("c1",  2'b00, 1'b0, 1'b0, 16'd0);
    smp(1'b1, 4'd5, 1'b0, 1'b0, 1'b1);  chk_out("c5",  2'b00, 1'b0, 1'b0, 16'd0);
    smp(1'b1, 4'd6);                    chk_out("c6",  2'b01, 1'b0, 1'b0, 16'd1);

    // Reset overrides clear
    @(negedge clk);
    rst = 1'b1;
    bus.clr_err_311 = 1'b1;
    bus.valid_311 = 1'b1;
    bus.count_in_311 = 4'd7;
    @(posedge clk);
    #1;
    chk_out("rstclr", 2'b11, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    bus.clr_err_311 = 1'b0;
    bus.valid_311 = 1'b0;

    // Reversals: 2,3,2,3 and 2,3,3,2
`ifdef COUNT_MON_REVERSALS_EN
    rev_exp = 8'd2;
`else
    rev_exp = 8'd0;
`endif
    rst_cycle();
    smp(1'b1, 4'd2); smp(1'b1, 4'd3); smp(1'b1, 4'd2); smp(1'b1, 4'd3);
    chk("rev2323", {24'd0, bus.reversals_311}, {24'd0, rev_exp});
    chk_out("r2323", 2'b01, 1'b0, 1'b0, 16'd3);
    rst_cycle();
    smp(1'b1, 4'd2); smp(1'b1, 4'd3); smp(1'b1, 4'd3); smp(1'b1, 4'd2);
    chk("rev2332", {24'd0, bus.reversals_311}, 32'd0);
    chk_out("r2332", 2'b10, 1'b0, 1'b0, 16'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
